// File: rtl/fft_sample_buffer.sv
// Complex sample store between the Wishbone slave and the FFT core: streams
// stored samples out in bit-reversed order and captures results in natural order.
module fft_sample_buffer #(
    parameter int sample           = 8,
    parameter int n_bit_for_sample = 3
) (
    input  logic                        CLK_I,
    input  logic                        RST_NI,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_sel_wishbone,
    input  logic [1:0]                  rd_sel_wishbone,
    input  logic [n_bit_for_sample-1:0] wishbone_addr,
    input  logic signed [31:0]          data_in,
    output logic signed [31:0]          data_out,
    input  logic                        start,
    output logic                        done,
    output logic                        err,
    output logic                        src_valid,
    input  logic                        src_ready,
    output logic signed [31:0]          src_re,
    output logic signed [31:0]          src_im,
    output logic                        src_last,
    input  logic                        res_valid,
    input  logic signed [31:0]          res_re,
    input  logic signed [31:0]          res_im,
    input  logic                        res_last
);

    localparam int CW = n_bit_for_sample + 1;
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(sample - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(sample);
    localparam logic [n_bit_for_sample-1:0] ZERO_IDX = n_bit_for_sample'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [n_bit_for_sample-1:0] bitrev(input logic [n_bit_for_sample-1:0] idx);
        logic [n_bit_for_sample-1:0] rev;
        for (int i = 0; i < n_bit_for_sample; i++) begin
            rev[i] = idx[n_bit_for_sample-1-i];
        end
        return rev;
    endfunction

    logic signed [31:0] in_re_r  [sample];
    logic signed [31:0] in_im_r  [sample];
    logic signed [31:0] out_re_r [sample];
    logic signed [31:0] out_im_r [sample];

    state_t                      state_r;
    logic                        start_d_r;
    logic [CW-1:0]               send_cnt_r;
    logic [CW-1:0]               res_cnt_r;

    logic                        trigger_s;
    logic                        wr_accept_s;
    logic                        capture_s;
    logic                        capture_final_s;
    logic                        beat_xfer_s;
    logic [CW-1:0]               next_cnt_s;
    logic [n_bit_for_sample-1:0] next_addr_s;
    logic [n_bit_for_sample-1:0] res_addr_s;
    logic                        unused_rd_sel_s;

    assign unused_rd_sel_s = rd_sel_wishbone[1];

    // Handshake decode: trigger, write acceptance, result capture and beat transfer
    always_comb begin
        trigger_s       = start & ~start_d_r;
        wr_accept_s     = 1'b0;
        capture_s       = 1'b0;
        beat_xfer_s     = 1'b0;
        next_cnt_s      = send_cnt_r + ONE_CNT;
        next_addr_s     = bitrev(next_cnt_s[n_bit_for_sample-1:0]);
        res_addr_s      = res_cnt_r[n_bit_for_sample-1:0];
        if (state_r == ST_IDLE || state_r == ST_DONE) begin
            wr_accept_s = wr_en & wr_sel_wishbone[1];
        end else begin
            // Count guard keeps stray results after the last one out of the banks
            capture_s = res_valid & (res_cnt_r < FULL_CNT);
        end
        if (state_r == ST_SEND) begin
            beat_xfer_s = src_valid & src_ready;
        end else begin
            beat_xfer_s = 1'b0;
        end
        capture_final_s = capture_s & (res_cnt_r == LAST_IDX);
    end

    // Input banks written from the Wishbone side while the core is not busy
    always_ff @(posedge CLK_I) begin
        if (wr_accept_s) begin
            if (wr_sel_wishbone[0]) begin
                in_im_r[wishbone_addr] <= data_in;
            end else begin
                in_re_r[wishbone_addr] <= data_in;
            end
        end
    end

    // Result banks filled in natural order from the core's result stream
    always_ff @(posedge CLK_I) begin
        if (capture_s) begin
            out_re_r[res_addr_s] <= res_re;
            out_im_r[res_addr_s] <= res_im;
        end
    end

    // Registered Wishbone read port
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            data_out <= 32'sd0;
        end else begin
            data_out <= rd_sel_wishbone[0] ? out_im_r[wishbone_addr] : out_re_r[wishbone_addr];
        end
    end

    // Control FSM with registered source beat and status outputs
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_r    <= ST_IDLE;
            start_d_r  <= 1'b1;
            send_cnt_r <= ZERO_CNT;
            res_cnt_r  <= ZERO_CNT;
            done       <= 1'b0;
            err        <= 1'b0;
            src_valid  <= 1'b0;
            src_re     <= 32'sd0;
            src_im     <= 32'sd0;
            src_last   <= 1'b0;
        end else begin
            start_d_r <= start;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (trigger_s) begin
                        state_r    <= ST_SEND;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        send_cnt_r <= ZERO_CNT;
                        res_cnt_r  <= ZERO_CNT;
                        src_valid  <= 1'b1;
                        src_re     <= in_re_r[bitrev(ZERO_IDX)];
                        src_im     <= in_im_r[bitrev(ZERO_IDX)];
                        src_last   <= 1'b0;
                    end else if (wr_accept_s) begin
                        state_r <= ST_IDLE;
                        done    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (beat_xfer_s) begin
                        if (src_last) begin
                            src_valid <= 1'b0;
                            src_last  <= 1'b0;
                            // Results may already be complete when the last beat leaves
                            if (res_cnt_r == FULL_CNT || capture_final_s) begin
                                state_r <= ST_DONE;
                                done    <= 1'b1;
                            end else begin
                                state_r <= ST_COLLECT;
                            end
                        end else begin
                            send_cnt_r <= next_cnt_s;
                            src_re     <= in_re_r[next_addr_s];
                            src_im     <= in_im_r[next_addr_s];
                            src_last   <= (next_cnt_s == LAST_IDX);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (capture_final_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (capture_s) begin
                res_cnt_r <= res_cnt_r + ONE_CNT;
                if (res_last != (res_cnt_r == LAST_IDX)) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Randomized self-checking bench for fft_sample_buffer against an array/queue
// reference model of the sample store, bit-reversed send and result capture.
module tb_fft_sample_buffer;

    localparam int N  = 8;
    localparam int NB = 3;

    logic               CLK_I = 1'b0;
    logic               RST_NI;
    logic               wr_en;
    logic [1:0]         wr_sel_wishbone;
    logic [1:0]         rd_sel_wishbone;
    logic [NB-1:0]      wishbone_addr;
    logic signed [31:0] data_in;
    logic signed [31:0] data_out;
    logic               start;
    logic               done;
    logic               err;
    logic               src_valid;
    logic               src_ready;
    logic signed [31:0] src_re;
    logic signed [31:0] src_im;
    logic               src_last;
    logic               res_valid;
    logic signed [31:0] res_re;
    logic signed [31:0] res_im;
    logic               res_last;

    fft_sample_buffer #(.sample(N), .n_bit_for_sample(NB)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI),
        .wr_en(wr_en), .wr_sel_wishbone(wr_sel_wishbone), .rd_sel_wishbone(rd_sel_wishbone),
        .wishbone_addr(wishbone_addr), .data_in(data_in), .data_out(data_out),
        .start(start), .done(done), .err(err),
        .src_valid(src_valid), .src_ready(src_ready), .src_re(src_re), .src_im(src_im),
        .src_last(src_last),
        .res_valid(res_valid), .res_re(res_re), .res_im(res_im), .res_last(res_last)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_in_re  [N];
    logic [31:0] m_in_im  [N];
    logic [31:0] m_out_re [N];
    logic [31:0] m_out_im [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int b = 0; b < NB; b++) begin
            if (((k >> b) & 1) == 1) r += 1 << (NB - 1 - b);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wb_write(input bit im, input int addr, input logic [31:0] d);
        wr_en           = 1'b1;
        wr_sel_wishbone = {1'b1, im};
        wishbone_addr   = NB'(addr);
        data_in         = d;
        tick();
        wr_en           = 1'b0;
        wr_sel_wishbone = 2'b00;
        if (im) m_in_im[addr] = d;
        else    m_in_re[addr] = d;
    endtask

    task automatic load_banks(input bit rnd);
        for (int i = 0; i < N; i++) begin
            wb_write(1'b0, i, rnd ? 32'($urandom) : 32'(i + 1));
            wb_write(1'b1, i, rnd ? 32'($urandom) : 32'(-(i + 1)));
        end
    endtask

    task automatic readback();
        for (int a = 0; a < N; a++) begin
            for (int s = 0; s < 2; s++) begin
                rd_sel_wishbone = {1'b0, s[0]};
                wishbone_addr   = NB'(a);
                tick();
                check($sformatf("rd_a%0d_s%0d", a, s), data_out, (s == 1) ? m_out_im[a] : m_out_re[a]);
            end
        end
    endtask

    // ready_mode: 0 always ready, 1 alternating 1/0, 2 random
    task automatic run_fft(input int ready_mode, input int last_at, input bit busy_wr, input bit fixed_res);
        int beats = 0;
        int results = 0;
        bit finished = 1'b0;
        bit held = 1'b0;
        bit fin_now;
        logic [31:0] h_re, h_im;
        logic h_last;
        int idx;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            case (ready_mode)
                0:       src_ready = 1'b1;
                1:       src_ready = (cyc % 2 == 0);
                default: src_ready = 1'($urandom_range(0, 1));
            endcase
            if (results < N && $urandom_range(0, 2) != 0) begin
                res_valid = 1'b1;
                res_re    = fixed_res ? 32'(100 + results) : 32'($urandom);
                res_im    = fixed_res ? 32'(200 + results) : 32'($urandom);
                res_last  = (results == last_at);
            end else begin
                res_valid = 1'b0;
                res_last  = 1'b0;
            end
            wr_en = 1'b0;
            if (busy_wr && cyc == 2 && beats < N) begin
                wr_en           = 1'b1;
                wr_sel_wishbone = 2'b10;
                wishbone_addr   = NB'(2);
                data_in         = 32'sd999;
            end
            start = (cyc == 3 && beats < N);
            @(negedge CLK_I);
            fin_now = (beats == N && results == N);
            check("src_valid", 32'(src_valid), 32'(beats < N));
            check("done", 32'(done), 32'(fin_now));
            if (cyc == 0) check("err_cleared", 32'(err), 32'd0);
            if (held) begin
                check("hold_re", src_re, h_re);
                check("hold_im", src_im, h_im);
                check("hold_last", 32'(src_last), 32'(h_last));
            end
            held = 1'b0;
            if (src_valid && src_ready) begin
                idx = rev_idx(beats);
                check($sformatf("beat%0d_re", beats), src_re, m_in_re[idx]);
                check($sformatf("beat%0d_im", beats), src_im, m_in_im[idx]);
                check($sformatf("beat%0d_last", beats), 32'(src_last), 32'(beats == N - 1));
                beats++;
            end else if (src_valid) begin
                held   = 1'b1;
                h_re   = src_re;
                h_im   = src_im;
                h_last = src_last;
            end
            if (res_valid) begin
                m_out_re[results] = res_re;
                m_out_im[results] = res_im;
                results++;
            end
            finished = fin_now;
            tick();
        end
        src_ready = 1'b0;
        res_valid = 1'b0;
        res_last  = 1'b0;
        wr_en     = 1'b0;
        start     = 1'b0;
        if (!finished) check("run_timeout", 32'd0, 32'd1);
        check("err_final", 32'(err), 32'(last_at != N - 1));
        check("done_final", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_NI = 1'b0;  start = 1'b1;  wr_en = 1'b0;  wr_sel_wishbone = 2'b00;
        rd_sel_wishbone = 2'b00;  wishbone_addr = '0;  data_in = '0;
        src_ready = 1'b0;  res_valid = 1'b0;  res_re = '0;  res_im = '0;  res_last = 1'b0;
        #1;
        check("rst_data_out", data_out, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_src_valid", 32'(src_valid), 32'd0);
        check("rst_src_re", src_re, 32'd0);
        check("rst_src_im", src_im, 32'd0);
        check("rst_src_last", 32'(src_last), 32'd0);
        tick(); tick();
        RST_NI = 1'b1;
        // start held high through reset must not fire
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_I);
            check("no_fire_after_rst", 32'(src_valid), 32'd0);
            tick();
        end
        start = 1'b0;
        tick();

        // Ordering with fixed pattern and fixed results
        load_banks(1'b0);
        run_fft(0, N - 1, 1'b0, 1'b1);
        readback();

        // Backpressure, early last and a write attempted while busy
        run_fft(1, 5, 1'b1, 1'b1);
        readback();

        // Busy write must have been dropped; err cleared by this trigger
        run_fft(2, N - 1, 1'b0, 1'b0);
        readback();

        // Write accepted in DONE clears done
        wb_write(1'b0, 0, 32'($urandom));
        check("done_cleared_by_write", 32'(done), 32'd0);
        load_banks(1'b1);
        for (int r = 0; r < 4; r++) begin
            run_fft(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : N - 1,
                    1'($urandom_range(0, 1)), 1'b0);
            readback();
            load_banks(1'b1);
        end

        // Asynchronous reset in the middle of sending, start held high
        start = 1'b1;
        src_ready = 1'b1;
        tick(); tick(); tick();
        #2;
        RST_NI = 1'b0;
        #1;
        check("midrst_src_valid", 32'(src_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_src_last", 32'(src_last), 32'd0);
        check("midrst_src_re", src_re, 32'd0);
        check("midrst_data_out", data_out, 32'd0);
        tick(); tick();
        RST_NI = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_I);
            check("midrst_no_beats", 32'(src_valid), 32'd0);
            tick();
        end
        start = 1'b0;
        src_ready = 1'b0;
        tick();
        run_fft(2, N - 1, 1'b0, 1'b0);
        readback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sample_buffer.md
# fft_sample_buffer

Complex sample store between `wishbone_slave` and the FFT datapath. The Wishbone side fills real and imaginary input banks and reads back result banks. On a rising edge of `start` the block streams the stored samples to the FFT core in bit-reversed order over a valid/ready channel. It then captures the core's result stream in natural order and raises `done`.

## Interface
- `sample`, 8, number of complex points; power of two, ≥ 2.
- `n_bit_for_sample`, 3, log2(`sample`); width of all indices.

- `CLK_I` in 1: single clock; all logic on the rising edge.
- `RST_NI` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: write strobe from `wishbone_slave`.
- `wr_sel_wishbone` in 2: `2'b10` selects the real input bank, `2'b11` the imaginary input bank; other codes mean no write.
- `rd_sel_wishbone` in 2: bit 0 = 0 selects result real, 1 selects result imaginary.
- `wishbone_addr` in `n_bit_for_sample`: bank index for both writes and reads.
- `data_in` in 32 signed: write data, driven by the slave's `data_out`.
- `data_out` out 32 signed: registered read data, consumed by the slave's `data_in`.
- `start` in 1: level from the slave; only its rising edge is used.
- `done` out 1: results complete; stays high until cleared.
- `err` out 1: sticky flag; `res_last` disagreed with the internal result count.
- `src_valid` out 1: sample beat valid toward the FFT core.
- `src_ready` in 1: FFT core accepts the beat.
- `src_re`, `src_im` out 32 signed: sample beat data.
- `src_last` out 1: marks the final beat.
- `res_valid` in 1: result beat from the core; this block has no backpressure.
- `res_re`, `res_im` in 32 signed: result beat data.
- `res_last` in 1: core's marker for the final result beat.

## Operation
- Storage: four banks of `sample` × 32-bit registers: in_re, in_im, out_re, out_im. Bank contents are not reset.
- Writes:
  - Accepted only in IDLE or DONE, when `wr_en`=1 and `wr_sel_wishbone[1]`=1.
  - Bit 0 of `wr_sel_wishbone` selects the im bank (1) or the re bank (0).
  - A write accepted in DONE clears `done` and moves the FSM to IDLE.
  - Writes in SEND or COLLECT are ignored.
- Reads: every cycle, `data_out` <= `rd_sel_wishbone[0]` ? out_im[`wishbone_addr`] : out_re[`wishbone_addr`].
- Start detect: `start_d` is a register of `start`, with reset value 1. A trigger is `start` & ~`start_d`, so a level held high through reset does not fire.
- FSM states: IDLE, SEND, COLLECT, DONE.
  - IDLE/DONE → SEND on a trigger. On the same edge:
    - `done` <= 0, `err` <= 0, send count <= 0, result count <= 0.
    - Beat 0 is loaded: `src_valid` <= 1.
  - SEND: beat k carries in_re/in_im[bitrev(k)], where bitrev reverses `n_bit_for_sample` bits.
    - On `src_valid` & `src_ready`: advance k and load the next beat on the same edge, so there are no bubbles.
    - `src_last` = (k == `sample`-1).
    - After the last beat transfers: `src_valid` <= 0 and the FSM goes to COLLECT.
  - Result capture is active in both SEND and COLLECT; results may overlap sending.
    - On `res_valid`: out_re/out_im[r] <= `res_re`/`res_im`, then r increments.
    - If `res_last` != (r == `sample`-1), `err` <= 1.
  - COLLECT → DONE on the edge that captures r = `sample`-1. If that capture happens while still in SEND, DONE is entered after the last send beat transfers.
  - DONE: `done`=1.
- `res_valid` in IDLE or DONE is ignored.
- Counters are `n_bit_for_sample`+1 bits wide, so no wrap occurs before the terminal compare.
- A trigger while in SEND or COLLECT is ignored.

## Timing
- Reset values: `data_out`=0, `done`=0, `err`=0, `src_valid`=0, `src_re`=0, `src_im`=0, `src_last`=0, FSM=IDLE, counters 0.
- Reset is asynchronous: asserting `RST_NI` mid-operation forces all outputs to their reset values immediately and aborts any transfer.
- `src_valid` rises 1 cycle after the edge where `start` is first sampled high.
- With `src_ready` held at 1, the `sample` beats occupy `sample` consecutive cycles.
- While `src_ready`=0, the beat holds stable.
- `done` rises 1 cycle after the edge that captures the final result.
- Read latency is 1 cycle from `wishbone_addr`/`rd_sel_wishbone` to `data_out`.
- A write is visible to a subsequent send on the next cycle.

## Test plan
- Ordering: write re[i]=i+1, im[i]=-(i+1) for i=0..7, pulse `start`, hold `src_ready`=1.
  - Expect 8 back-to-back beats with `src_re` = 1,5,3,7,2,6,4,8.
  - Expect `src_im` to be the negated values, and `src_last` only on the 8th beat.
- Backpressure: toggle `src_ready` 1,0,1,0 during sending.
  - Expect each beat to hold stable while ready is low, with the same order as above.
- Capture: return res_re=100+k, res_im=200+k for k=0..7 with gaps in `res_valid`.
  - Expect `done`=1 one cycle after the 8th beat.
  - Read addr 3 with sel `2'b00` → `data_out`=103 next cycle; sel `2'b01` → 203.
- Early last: assert `res_last` at k=5.
  - Expect `err`=1, `done` still asserted after 8 results, and `err` cleared by the next trigger.
- Busy write: during SEND, write 999 to re addr 2.
  - Expect it ignored: the next run still emits re[2]=3.
- Reset mid-SEND: pull `RST_NI` low with `start` held high.
  - Expect `src_valid`=0 and `done`=0 immediately.
  - After release, expect no beats until `start` falls and rises again.
